// File: rtl/ahb_slave.sv
// AHB-Lite memory slave: DEPTH words with byte-lane writes.
// The number of wait states per data phase is set by a parameter.
module ahb_slave #(
  parameter int              AW          = 32,
  parameter int              DW          = 32,
  parameter logic [AW-1:0]   BASE        = '0,
  parameter int              DEPTH       = 20,
  parameter int              WAIT_STATES = 0
) (
  input  logic          hclk,
  input  logic          hreset_n,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic [2:0]    hsize,
  input  logic          hwrite,
  input  logic [DW-1:0] hwdata,
  output logic [DW-1:0] hrdata,
  input  logic          hready_i,
  output logic          hready_o
);

  localparam int            IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LIMIT = AW'(DEPTH * 4);
  localparam logic [2:0]    WS    = 3'(WAIT_STATES);

  logic [31:0]   mem [DEPTH];
  logic          dvalid;
  logic          dwrite;
  logic [AW-1:0] daddr;
  logic [2:0]    dsize;
  logic [2:0]    wcnt;
  logic          accept;
  logic          done;
  logic          inr;
  logic [AW-1:0] off;
  logic [IW-1:0] idx;
  logic [3:0]    be;

  assign off      = daddr - BASE;
  assign inr      = off < LIMIT;
  assign idx      = off[IW+1:2];
  assign hready_o = !(dvalid && wcnt != 3'd0);
  assign done     = dvalid && hready_o;
  assign accept   = hsel && hready_i && htrans[1] && hready_o;
  assign hrdata   = (dvalid && !dwrite && inr) ? mem[idx] : '0;

  always_comb begin
    be = 4'b0000;
    unique case (1'b1)
      dsize == 3'd0: be[daddr[1:0]] = 1'b1;
      dsize == 3'd1: be = daddr[1] ? 4'b1100 : 4'b0011;
      default:       be = 4'b1111;
    endcase
  end

  // A completing data phase may be overlapped by the next accepted address.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      dvalid <= 1'b0;
      dwrite <= 1'b0;
      daddr  <= '0;
      dsize  <= '0;
      wcnt   <= '0;
    end else if (accept) begin
      dvalid <= 1'b1;
      dwrite <= hwrite;
      daddr  <= haddr;
      dsize  <= hsize;
      wcnt   <= WS;
    end else if (done) begin
      dvalid <= 1'b0;
    end else if (dvalid) begin
      wcnt <= wcnt - 3'd1;
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (done && dwrite && inr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= hwdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_slave.sv
// Randomized bench for ahb_slave against a transfer-level memory model.
// A second instance exercises the wait-state path.
module tb_ahb_slave;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic        hsel;
  logic        sel2;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready_i;
  logic [31:0] hrdata0;
  logic [31:0] hrdata2;
  logic        hready0;
  wire         rdy2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          v;
    bit          wr;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] d;
  } op_t;

  logic [31:0] model [20];
  op_t         pend;

  always #5 hclk = ~hclk;

  ahb_slave u0 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr),
    .htrans(htrans), .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata),
    .hrdata(hrdata0), .hready_i(hready_i), .hready_o(hready0)
  );

  ahb_slave #(.WAIT_STATES(2)) u2 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(sel2), .haddr(haddr),
    .htrans(htrans), .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata),
    .hrdata(hrdata2), .hready_i(rdy2), .hready_o(rdy2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd();
    if (pend.v && !pend.wr && pend.a < 32'd80) return model[pend.a >> 2];
    return 32'h0;
  endfunction

  task automatic mwrite(input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] d);
    int k;
    bit en;
    if (a >= 32'd80) return;
    k = int'(a >> 2);
    for (int b = 0; b < 4; b++) begin
      if (sz == 3'd0) en = (b == int'(a[1:0]));
      else if (sz == 3'd1) en = ((b / 2) == int'(a[1]));
      else en = 1'b1;
      if (en) model[k][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Entered at posedge+1: drives one address phase plus the pending data phase.
  task automatic step(input bit sel, input logic [1:0] tr, input bit wr,
                      input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] d);
    hsel = sel; htrans = tr; hwrite = wr; haddr = a; hsize = sz;
    hwdata = (pend.v && pend.wr) ? pend.d : $urandom;
    @(negedge hclk);
    check("ready0", {31'b0, hready0}, 32'd1);
    check("rdata0", hrdata0, exp_rd());
    @(posedge hclk);
    if (pend.v && pend.wr) mwrite(pend.a, pend.sz, pend.d);
    pend.v = sel && tr[1];
    pend.wr = wr; pend.a = a; pend.sz = sz; pend.d = d;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0);
  endtask

  task automatic do_reset();
    hreset_n = 1'b0;
    #3;
    check("rst_ready", {31'b0, hready0}, 32'd1);
    check("rst_rdata", hrdata0, 32'h0);
    for (int i = 0; i < 20; i++) model[i] = '0;
    pend.v = 1'b0;
    @(posedge hclk); #2;
    hreset_n = 1'b1;
    @(posedge hclk); #1;
  endtask

  task automatic ws_xfer(input bit wr, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd);
    int n;
    sel2 = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = 3'd2;
    @(posedge hclk); #1;
    sel2 = 1'b0; htrans = 2'b00; hwdata = d;
    n = 0;
    @(negedge hclk);
    while (!rdy2 && n < 10) begin
      n++;
      @(negedge hclk);
    end
    rd = hrdata2;
    check("ws_low_cycles", n, 32'd2);
    @(posedge hclk); #1;
  endtask

  initial begin
    logic [31:0] a, d, rd;
    logic [2:0]  sz;
    hsel = 0; sel2 = 0; haddr = 0; htrans = 0; hsize = 2;
    hwrite = 0; hwdata = 0; hready_i = 1; pend.v = 0;
    do_reset();

    // single word write then read
    step(1, 2'b10, 1, 32'h00, 3'd2, 32'hDEADBEEF);
    step(1, 2'b10, 0, 32'h00, 3'd2, 32'h0);
    idle();
    check("deadbeef_model", model[0], 32'hDEADBEEF);

    // sweep, each read pipelined behind its write
    for (int i = 0; i < 1000; i++) begin
      a = 32'((i % 20) * 4);
      step(1, 2'b10, 1, a, 3'd2, $urandom);
      step(1, 2'b11, 0, a, 3'd2, 32'h0);
    end
    idle();

    // byte and halfword lanes
    step(1, 2'b10, 1, 32'h08, 3'd2, 32'h11223344);
    step(1, 2'b10, 1, 32'h09, 3'd0, 32'h0000AA00);
    step(1, 2'b10, 0, 32'h08, 3'd2, 32'h0);
    step(1, 2'b10, 1, 32'h0A, 3'd1, 32'hBEEF0000);
    step(1, 2'b10, 0, 32'h08, 3'd2, 32'h0);
    idle();
    check("lanes_model", model[2], 32'hBEEFAA44);

    // out of range
    step(1, 2'b10, 1, 32'h50, 3'd2, 32'hCAFEF00D);
    step(1, 2'b10, 0, 32'h50, 3'd2, 32'h0);
    idle();

    // not accepted: IDLE, BUSY, unselected
    step(1, 2'b00, 1, 32'h10, 3'd2, 32'h5A5A5A5A);
    step(1, 2'b01, 1, 32'h10, 3'd2, 32'h5A5A5A5A);
    step(0, 2'b10, 1, 32'h10, 3'd2, 32'h5A5A5A5A);
    step(1, 2'b10, 0, 32'h10, 3'd2, 32'h0);
    idle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      sz = 3'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 32'h5F));
      if (sz == 3'd1) a[0] = 1'b0;
      if (sz == 3'd2) a[1:0] = 2'b00;
      step(($urandom % 4) != 0, 2'($urandom), 1'($urandom), a, sz, $urandom);
    end
    idle();
    for (int i = 0; i < 20; i++) step(1, 2'b10, 0, 32'(i * 4), 3'd2, 32'h0);
    idle();

    // wait-state instance
    ws_xfer(1, 32'h04, 32'h0BADCAFE, rd);
    ws_xfer(0, 32'h04, 32'h0, rd);
    check("ws_rdata", rd, 32'h0BADCAFE);

    // reset aborts a pending write
    do_reset();
    step(1, 2'b10, 1, 32'h0C, 3'd2, 32'h12345678);
    hsel = 0; htrans = 2'b00; hwdata = 32'h12345678;
    #2;
    hreset_n = 1'b0;
    #1;
    check("abort_ready", {31'b0, hready0}, 32'd1);
    check("abort_rdata", hrdata0, 32'h0);
    pend.v = 1'b0;
    @(posedge hclk); #2;
    hreset_n = 1'b1;
    @(posedge hclk); #1;
    for (int i = 0; i < 20; i++) step(1, 2'b10, 0, 32'(i * 4), 3'd2, 32'h0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
